// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: default geometry,
// clear-engine state encoding and the byte merge used by writes and bypass.
package regfile_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 5;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

  // One byte lane of a strobed write: take the new byte when enabled.
  function automatic logic [7:0] merge_byte(input logic [7:0] old_b,
                                            input logic [7:0] new_b,
                                            input logic       en);
    return en ? new_b : old_b;
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Bus bundle between the pipeline (master) and the register file (slave):
// write port, flattened read ports, and the clear request / busy status.
interface regfile_mp_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_READ   = 2
);

  logic                           clear;
  logic                           busy;
  logic                           we;
  logic [ADDR_WIDTH-1:0]          waddr;
  logic [DATA_WIDTH-1:0]          wdata;
  logic [DATA_WIDTH/8-1:0]        wstrb;
  logic [NUM_READ*ADDR_WIDTH-1:0] raddr;
  logic [NUM_READ*DATA_WIDTH-1:0] rdata;

  modport master (
    output clear, we, waddr, wdata, wstrb, raddr,
    input  busy, rdata
  );

  modport slave (
    input  clear, we, waddr, wdata, wstrb, raddr,
    output busy, rdata
  );

endinterface

// File: rtl/regfile_rdport.sv
// Single combinational read port: zero register, clear-in-progress blanking
// and optional same-cycle write forwarding on top of the stored entry.
module regfile_rdport
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic [ADDR_WIDTH-1:0]   raddr,
  input  logic [DATA_WIDTH-1:0]   stored,
  input  logic                    busy,
  input  logic                    we,
  input  logic [ADDR_WIDTH-1:0]   waddr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  output logic [DATA_WIDTH-1:0]   rdata
);

  localparam int NBYTES = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] fwd;
  logic                  zero_hit;
  logic                  byp_hit;

  assign zero_hit = (ZERO_REG != 0) && (raddr == '0);
  assign byp_hit  = (BYPASS != 0) && we && (waddr == raddr);

  // Forwarded view: stored entry with the strobed bytes of the pending write.
  always_comb begin
    fwd = stored;
    for (int k = 0; k < NBYTES; k++) begin
      fwd[k*8 +: 8] = merge_byte(stored[k*8 +: 8], wdata[k*8 +: 8], wstrb[k]);
    end
  end

  // Output select: an active sweep and the zero register override forwarding.
  always_comb begin
    if (busy || zero_hit) begin
      rdata = '0;
    end else if (byp_hit) begin
      rdata = fwd;
    end else begin
      rdata = stored;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file for the ID stage. Holds the
// unreset storage array, the strobed write path and the sequential clear
// engine that zeroes one entry per cycle after reset or on request.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_READ   = 2,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic         clk,
  input  logic         rst,
  regfile_mp_if.slave  bus
);

  localparam int DEPTH  = 2 ** ADDR_WIDTH;
  localparam int NBYTES = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  clr_state_e            state;
  logic [ADDR_WIDTH-1:0] clr_idx;
  logic                  busy_q;

  logic                  wr_ok;
  logic [DATA_WIDTH-1:0] wr_old;
  logic [DATA_WIDTH-1:0] wr_merged;

  wire  [NUM_READ*DATA_WIDTH-1:0] rdata_all;

  // Clear engine: reset or an idle clear request starts a full sweep from
  // entry 0; the sweep ends after the last entry and clr_idx then holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_CLEAR;
      clr_idx <= '0;
      busy_q  <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.clear) begin
            state   <= ST_CLEAR;
            clr_idx <= '0;
            busy_q  <= 1'b1;
          end
        end
        ST_CLEAR: begin
          if (&clr_idx) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
          end else begin
            clr_idx <= clr_idx + 1'b1;
          end
        end
        default: begin
          state   <= ST_CLEAR;
          clr_idx <= '0;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;

  // Writes only land while idle; the zero register swallows writes to 0.
  assign wr_ok  = bus.we && (state == ST_IDLE) &&
                  !((ZERO_REG != 0) && (bus.waddr == '0));
  assign wr_old = mem[bus.waddr];

  // Byte-strobed merge of the write data into the current entry.
  always_comb begin
    wr_merged = wr_old;
    for (int k = 0; k < NBYTES; k++) begin
      wr_merged[k*8 +: 8] = merge_byte(wr_old[k*8 +: 8], bus.wdata[k*8 +: 8],
                                       bus.wstrb[k]);
    end
  end

  // Storage update: the sweep owns the array while running, else the write port.
  always_ff @(posedge clk) begin
    if (state == ST_CLEAR) begin
      mem[clr_idx] <= '0;
    end else if (wr_ok) begin
      mem[bus.waddr] <= wr_merged;
    end
  end

  for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
    logic [ADDR_WIDTH-1:0] ra;
    assign ra = bus.raddr[i*ADDR_WIDTH +: ADDR_WIDTH];

    regfile_rdport #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .ZERO_REG   (ZERO_REG),
      .BYPASS     (BYPASS)
    ) u_rdport (
      .raddr  (ra),
      .stored (mem[ra]),
      .busy   (busy_q),
      .we     (bus.we),
      .waddr  (bus.waddr),
      .wdata  (bus.wdata),
      .wstrb  (bus.wstrb),
      .rdata  (rdata_all[i*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  assign bus.rdata = rdata_all;

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: two instances (zero-reg+bypass, and neither) driven
// with identical stimulus and compared against a behavioural model.
module tb_regfile_mp;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NR    = 4;
  localparam int DEPTH = 2 ** AW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          clear;
  logic          we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic [3:0]    wstrb;
  logic [AW-1:0] raddr [NR];
  logic [NR*AW-1:0] ra_flat;

  always_comb begin
    ra_flat = '0;
    for (int p = 0; p < NR; p++) ra_flat[p*AW +: AW] = raddr[p];
  end

  regfile_mp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR)) bus_a ();
  regfile_mp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR)) bus_b ();

  assign bus_a.clear = clear;
  assign bus_a.we    = we;
  assign bus_a.waddr = waddr;
  assign bus_a.wdata = wdata;
  assign bus_a.wstrb = wstrb;
  assign bus_a.raddr = ra_flat;
  assign bus_b.clear = clear;
  assign bus_b.we    = we;
  assign bus_b.waddr = waddr;
  assign bus_b.wdata = wdata;
  assign bus_b.wstrb = wstrb;
  assign bus_b.raddr = ra_flat;

  regfile_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR),
               .ZERO_REG(1), .BYPASS(1)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  regfile_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR),
               .ZERO_REG(0), .BYPASS(0)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  int n_cmp = 0;
  int n_err = 0;

  // model state: index 0 = instance A (zero reg, bypass), 1 = instance B
  logic [DW-1:0] mem_m [2][DEPTH];
  int            busy_left = 0;

  task automatic check(input string tag, input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_v,
                                          input logic [DW-1:0] new_v,
                                          input logic [3:0] s);
    logic [DW-1:0] r;
    r = old_v;
    for (int k = 0; k < 4; k++) if (s[k]) r[k*8 +: 8] = new_v[k*8 +: 8];
    return r;
  endfunction

  function automatic logic [DW-1:0] exp_rd(input int d, input logic [AW-1:0] a);
    if (rst || busy_left > 0) return '0;
    if (d == 0 && a == 0) return '0;
    if (d == 0 && we && a == waddr) return merge(mem_m[d][a], wdata, wstrb);
    return mem_m[d][a];
  endfunction

  function automatic logic [DW-1:0] rd_a(input int p);
    return bus_a.rdata[p*DW +: DW];
  endfunction

  function automatic logic [DW-1:0] rd_b(input int p);
    return bus_b.rdata[p*DW +: DW];
  endfunction

  task automatic zero_model();
    for (int i = 0; i < DEPTH; i++) begin
      mem_m[0][i] = '0;
      mem_m[1][i] = '0;
    end
  endtask

  // Abstract behaviour at a rising edge: a sweep simply blanks everything for
  // DEPTH cycles and leaves the array zero.
  task automatic model_edge();
    if (rst) begin
      busy_left = DEPTH;
      zero_model();
    end else if (busy_left > 0) begin
      busy_left--;
    end else begin
      if (we) begin
        if (waddr != 0) mem_m[0][waddr] = merge(mem_m[0][waddr], wdata, wstrb);
        mem_m[1][waddr] = merge(mem_m[1][waddr], wdata, wstrb);
      end
      if (clear) begin
        busy_left = DEPTH;
        zero_model();
      end
    end
  endtask

  task automatic check_outputs();
    logic eb;
    eb = rst || (busy_left > 0);
    check("busy_a", DW'(bus_a.busy), DW'(eb));
    check("busy_b", DW'(bus_b.busy), DW'(eb));
    for (int p = 0; p < NR; p++) begin
      check($sformatf("rd_a%0d@%0d", p, raddr[p]), rd_a(p), exp_rd(0, raddr[p]));
      check($sformatf("rd_b%0d@%0d", p, raddr[p]), rd_b(p), exp_rd(1, raddr[p]));
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_in();
    clear = 1'b0;
    we    = 1'b0;
    waddr = '0;
    wdata = '0;
    wstrb = '0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d,
                    input logic [3:0] s);
    we = 1'b1; waddr = a; wdata = d; wstrb = s;
    tick();
    we = 1'b0; wstrb = '0;
  endtask

  task automatic count_busy(input string tag);
    int n;
    n = 0;
    while (bus_a.busy && n < 100) begin
      tick();
      n++;
    end
    check(tag, DW'(n), DW'(DEPTH));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    idle_in();
    for (int p = 0; p < NR; p++) raddr[p] = 5'd5;
    tick();
    tick();
    rst = 1'b0;
    count_busy("rst_sweep_len");
    check("r5_after_sweep", rd_a(0), 32'h0);

    // strobed writes
    wr(5'd7, 32'hDEADBEEF, 4'hF);
    wr(5'd7, 32'h11223344, 4'h3);
    raddr[0] = 5'd7;
    #1;
    check("r7_merge_a", rd_a(0), 32'hDEAD3344);
    check("r7_merge_b", rd_b(0), 32'hDEAD3344);
    tick();

    // same-cycle forwarding
    we = 1'b1; waddr = 5'd9; wdata = 32'hCAFEF00D; wstrb = 4'hF; raddr[1] = 5'd9;
    #1;
    check("byp_a", rd_a(1), 32'hCAFEF00D);
    check("nobyp_b", rd_b(1), 32'h0);
    tick();
    we = 1'b0; wstrb = '0;
    #1;
    check("after_wr_b", rd_b(1), 32'hCAFEF00D);

    // zero register
    wr(5'd0, 32'hFFFFFFFF, 4'hF);
    for (int p = 0; p < NR; p++) raddr[p] = 5'd0;
    #1;
    for (int p = 0; p < NR; p++) check($sformatf("r0_a%0d", p), rd_a(p), 32'h0);
    check("r0_b", rd_b(0), 32'hFFFFFFFF);
    tick();

    // clear with a write attempted during the sweep
    wr(5'd3, 32'h55, 4'hF);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    we = 1'b1; waddr = 5'd4; wdata = 32'h66; wstrb = 4'hF;
    count_busy("clear_sweep_len");
    idle_in();
    raddr[0] = 5'd3; raddr[1] = 5'd4;
    #1;
    check("r3_cleared", rd_a(0), 32'h0);
    check("r4_dropped", rd_a(1), 32'h0);
    check("r4_dropped_b", rd_b(1), 32'h0);

    // four ports at once
    wr(5'd1, 32'hA1A1A1A1, 4'hF);
    wr(5'd2, 32'hB2B2B2B2, 4'hF);
    wr(5'd31, 32'hF31F31F3, 4'hF);
    raddr[0] = 5'd1; raddr[1] = 5'd2; raddr[2] = 5'd1; raddr[3] = 5'd31;
    #1;
    check("p0_r1", rd_a(0), 32'hA1A1A1A1);
    check("p1_r2", rd_a(1), 32'hB2B2B2B2);
    check("p2_r1", rd_a(2), 32'hA1A1A1A1);
    check("p3_r31", rd_a(3), 32'hF31F31F3);
    tick();

    // reset in the middle of a sweep restarts it from scratch
    clear = 1'b1;
    tick();
    clear = 1'b0;
    repeat (10) tick();
    rst = 1'b1;
    #1;
    check("busy_in_rst", DW'(bus_a.busy), 32'h1);
    tick();
    rst = 1'b0;
    count_busy("rst_mid_sweep_len");

    // randomized traffic against the model
    for (int c = 0; c < 1500; c++) begin
      clear = ($urandom_range(0, 49) == 0);
      we    = ($urandom_range(0, 2) != 0);
      waddr = AW'($urandom_range(0, 7) == 0 ? 0 : $urandom_range(0, DEPTH - 1));
      wdata = $urandom;
      wstrb = 4'($urandom);
      for (int p = 0; p < NR; p++)
        raddr[p] = ($urandom_range(0, 2) == 0) ? waddr
                                               : AW'($urandom_range(0, DEPTH - 1));
      rst = ($urandom_range(0, 299) == 0);
      tick();
      rst = 1'b0;
    end
    idle_in();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
